// File: rtl/dmem_copy_engine_pkg.sv
// Shared definitions for the data-memory copy/fill engine: FSM state
// encodings, command mode encodings and the word stride on the byte bus.
package dmem_copy_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic        MODE_COPY   = 1'b0;
    localparam logic        MODE_FILL   = 1'b1;
    localparam logic [15:0] WORD_STRIDE = 16'd2;

endpackage

// File: rtl/dmem_copy_engine.sv
// Bus initiator that copies (src->dst) or fills (fill_value->dst) blocks of
// 16-bit words on the shared data-memory/IO bus. Strobes are combinational
// in bus_gnt so a stalled cycle never issues an access.
// Optional feature macro: DMEM_COPY_CHECKSUM_EN adds a running 16-bit sum
// of every granted write; without it checksum is tied to zero.
module dmem_copy_engine
    import dmem_copy_engine_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      fill_value,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      checksum,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_write,
    output logic             mem_read,
    input  logic [15:0]      mem_rdata
);

    state_t           state_reg, state_next;
    logic [15:0]      src_reg, src_next;
    logic [15:0]      dst_reg, dst_next;
    logic [15:0]      data_reg, data_next;
    logic [15:0]      fill_reg, fill_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic             mode_reg, mode_next;
    logic             err_reg, err_next;

    // State, pointers, count and data latches; all clear on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            data_reg  <= '0;
            fill_reg  <= '0;
            rem_reg   <= '0;
            mode_reg  <= MODE_COPY;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            data_reg  <= data_next;
            fill_reg  <= fill_next;
            rem_reg   <= rem_next;
            mode_reg  <= mode_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic and bus strobes; abort wins over a grant in RD/WR.
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        data_next  = data_reg;
        fill_next  = fill_reg;
        rem_next   = rem_reg;
        mode_next  = mode_reg;
        err_next   = err_reg;
        bus_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        err        = (state_reg == DONE) && err_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (((mode == MODE_COPY) && src_addr[0]) || dst_addr[0]) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else if (len == '0) begin
                        state_next = DONE;
                        err_next   = 1'b0;
                    end else begin
                        src_next   = src_addr;
                        dst_next   = dst_addr;
                        rem_next   = len;
                        fill_next  = fill_value;
                        mode_next  = mode;
                        err_next   = 1'b0;
                        state_next = (mode == MODE_FILL) ? WR : RD;
                    end
                end
            end
            RD: begin
                bus_req = 1'b1;
                if (abort) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else if (bus_gnt) begin
                    mem_read   = 1'b1;
                    mem_addr   = src_reg;
                    data_next  = mem_rdata;
                    state_next = WR;
                end
            end
            WR: begin
                bus_req = 1'b1;
                if (abort) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else if (bus_gnt) begin
                    mem_write = 1'b1;
                    mem_addr  = dst_reg;
                    mem_wdata = (mode_reg == MODE_FILL) ? fill_reg : data_reg;
                    src_next  = src_reg + WORD_STRIDE;
                    dst_next  = dst_reg + WORD_STRIDE;
                    rem_next  = rem_reg - LEN_W'(1);
                    if (rem_reg == LEN_W'(1)) begin
                        state_next = DONE;
                        err_next   = 1'b0;
                    end else begin
                        state_next = (mode_reg == MODE_FILL) ? WR : RD;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef DMEM_COPY_CHECKSUM_EN
    logic [15:0] sum_reg, sum_next;

    // Running sum: cleared by an accepted start, accumulates granted writes.
    always_comb begin
        sum_next = sum_reg;
        if ((state_reg == IDLE) && start) begin
            sum_next = '0;
        end else if (mem_write) begin
            sum_next = sum_reg + mem_wdata;
        end
    end

    // Checksum register; holds after DONE until the next accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= sum_next;
        end
    end

    assign checksum = sum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: a word-array memory model stands
// in for the data memory (with the 0xfffa display port), a vector table
// drives commands, and expected writes are queued and popped on mem_write.
module tb_dmem_copy_engine;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  len;
    logic [15:0] fill_value;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_rdata;

    always #5 clock = ~clock;

    dmem_copy_engine #(.LEN_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_value (fill_value),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    function automatic logic [15:0] init_word(input int k);
        case (k)
            0:       return 16'h1111;
            1:       return 16'h2222;
            2:       return 16'h3333;
            16'h80:  return 16'hAAAA;
            16'h81:  return 16'h5555;
            default: return 16'(k) ^ 16'hC3C3;
        endcase
    endfunction

    // Memory model: combinational read, write on the clock edge.
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [6:0]  io_display = '0;
    logic        load_mem = 1'b0;

    assign mem_rdata = mem[mem_addr[15:1]];

    always @(posedge clock) begin
        if (load_mem) begin
            for (int k = 0; k < 32768; k++) mem[k] <= init_word(k);
        end else if (mem_write) begin
            mem[mem_addr[15:1]] <= mem_wdata;
            if (mem_addr == 16'hfffa) io_display <= mem_wdata[6:0];
        end
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];
    logic mon_en = 1'b0;

    // Bus monitor: protocol rules every cycle, scoreboard pop on each write.
    always @(negedge clock) begin
        if (reset_n && mon_en) begin
            check("bus_rules",
                  {31'd0, !((mem_read || mem_write) && !bus_gnt) && !(mem_read && mem_write) &&
                          ((mem_read || mem_write) || (mem_addr == 16'h0 && mem_wdata == 16'h0))},
                  32'd1);
            if (mem_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {mem_addr, mem_wdata}, 32'hDEADDEAD);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr_data", {mem_addr, mem_wdata}, {e.addr, e.data});
                    $display("write addr=%04h data=%04h", mem_addr, mem_wdata);
                end
            end
        end
    end

    typedef struct {
        logic        mode;
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  len;
        logic [15:0] fill;
        int          stall_at;
        int          stall_len;
        int          abort_at;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    // Runs one command; abort entries in the table abort before the first write.
    task automatic run_cmd(input vec_t v);
        logic [15:0] s, d, w, sum;
        logic        aligned;
        int          cyc;
        logic        seen;
        aligned = !(((v.mode == 1'b0) && v.src[0]) || v.dst[0]);
        s = v.src; d = v.dst; sum = 16'h0;
        if (aligned && v.len != 0 && v.abort_at < 0) begin
            for (int k = 0; k < int'(v.len); k++) begin
                w = v.mode ? v.fill : ref_mem[s[15:1]];
                ref_mem[d[15:1]] = w;
                exp_q.push_back({d, w});
                sum = sum + w;
                s = s + 16'd2;
                d = d + 16'd2;
            end
        end
        @(posedge clock); #1;
        mode = v.mode; src_addr = v.src; dst_addr = v.dst; len = v.len;
        fill_value = v.fill; start = 1'b1; bus_gnt = 1'b1; abort = 1'b0;
        cyc = 0; seen = 1'b0;
        while (cyc < 300 && !seen) begin
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
            bus_gnt = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
            abort = (cyc == v.abort_at);
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check("done_cycle", cyc, v.exp_cyc);
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("writes_pending", exp_q.size(), 0);
`ifdef DMEM_COPY_CHECKSUM_EN
        check("checksum", {16'd0, checksum}, {16'd0, sum});
`else
        check("checksum_tied", {16'd0, checksum}, 32'd0);
`endif
        $display("cmd mode=%0d src=%04h dst=%04h len=%0d done_cycle=%0d err=%0d",
                 v.mode, v.src, v.dst, v.len, cyc, err);
        @(posedge clock); #1;
        abort = 1'b0; bus_gnt = 1'b1;
        @(negedge clock);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        vec_t extra;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_value = '0; abort = 1'b0; bus_gnt = 1'b0;
        for (int k = 0; k < 32768; k++) ref_mem[k] = init_word(k);

        //          mode  src       dst       len  fill      st  sl  ab  err   cyc
        vecs[0] = '{1'b1, 16'h0000, 16'h0010, 8'd4, 16'hA5A5, 0, 0, -1, 1'b0, 5};
        vecs[1] = '{1'b0, 16'h0000, 16'h0040, 8'd3, 16'h0000, 0, 0, -1, 1'b0, 7};
        vecs[2] = '{1'b0, 16'h0100, 16'h0200, 8'd2, 16'h0000, 2, 2, -1, 1'b0, 7};
        vecs[3] = '{1'b0, 16'h0003, 16'h0080, 8'd2, 16'h0000, 0, 0, -1, 1'b1, 1};
        vecs[4] = '{1'b0, 16'h0000, 16'h0080, 8'd0, 16'h0000, 0, 0, -1, 1'b0, 1};
        vecs[5] = '{1'b1, 16'h0000, 16'hfffa, 8'd1, 16'h005B, 0, 0, -1, 1'b0, 2};
        vecs[6] = '{1'b1, 16'h0000, 16'hfffe, 8'd2, 16'h1234, 0, 0, -1, 1'b0, 3};
        vecs[7] = '{1'b0, 16'h0000, 16'h0300, 8'd3, 16'h0000, 0, 0,  2, 1'b1, 3};
        vecs[8] = '{1'b1, 16'h0000, 16'h0011, 8'd2, 16'h7777, 0, 0, -1, 1'b1, 1};
        vecs[9] = '{1'b0, 16'h0300, 16'h0400, 8'd1, 16'h0000, 1, 1, -1, 1'b0, 4};

        // Reset state (asynchronous) and memory preload.
        #1;
        check("reset_outputs",
              {busy, done, err, bus_req, mem_read, mem_write, 10'd0, mem_addr | mem_wdata | checksum},
              32'd0);
        load_mem = 1'b1;
        @(posedge clock); #1;
        load_mem = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i]);
            if (i == 0) begin
`ifdef DMEM_COPY_CHECKSUM_EN
                check("checksum_fill4", {16'd0, checksum}, 32'h9694);
`else
                check("checksum_off", {16'd0, checksum}, 32'd0);
`endif
            end
            if (i == 1) begin
                check("copy_word0", {16'd0, mem[16'h20]}, 32'h1111);
                check("copy_word1", {16'd0, mem[16'h21]}, 32'h2222);
                check("copy_word2", {16'd0, mem[16'h22]}, 32'h3333);
            end
            if (i == 2) check("stall_copy", {mem[16'h100], mem[16'h101]}, 32'hAAAA5555);
            if (i == 5) check("io_display", {25'd0, io_display}, 32'h5B);
            if (i == 6) check("wrap_to_zero", {16'd0, mem[0]}, 32'h1234);
        end

        // Reset in the middle of a copy: one word lands, then all outputs drop.
        exp_q.push_back({16'h0500, ref_mem[0]});
        ref_mem[16'h280] = ref_mem[0];
        @(posedge clock); #1;
        mode = 1'b0; src_addr = 16'h0000; dst_addr = 16'h0500; len = 8'd3;
        start = 1'b1; bus_gnt = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("reset_mid_copy",
              {busy, done, err, bus_req, mem_read, mem_write, 10'd0, mem_addr | mem_wdata | checksum},
              32'd0);
        check("reset_writes_pending", exp_q.size(), 0);
        $display("reset mid-copy busy=%0d bus_req=%0d", busy, bus_req);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_after_reset", {31'd0, busy}, 32'd0);
        check("partial_kept", {16'd0, mem[16'h280]}, {16'd0, ref_mem[16'h280]});

        extra = '{1'b1, 16'h0000, 16'h0600, 8'd1, 16'hBEEF, 0, 0, -1, 1'b0, 2};
        run_cmd(extra);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
